// File: rtl/gc_stream_collector.sv
// gc_stream_collector: receiving end of the garbler output stream.
// Pulses gc_start to arm the core, then decodes per-cycle tag/index/data words into label
// memory, garbled-table memory, two key registers and an output-mask register. Raises done
// when the mask word terminates the stream; the host then reads results through a 1-cycle
// synchronous read port.
// Optional feature: define GC_COLLECT_STATS_EN to build the label/table write counters and
// the protocol error flag; otherwise label_cnt, table_cnt and err are tied to 0.
module gc_stream_collector #(
   parameter int unsigned S = 8,
   parameter int unsigned K = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         arm,
   input  logic         clear,
   output logic         gc_start,
   input  logic [2:0]   tag,
   input  logic [S-1:0] index0,
   input  logic [S-1:0] index1,
   input  logic [K-1:0] data0,
   input  logic [K-1:0] data1,
   input  logic         rd_en,
   input  logic [1:0]   rd_sel,
   input  logic [S-1:0] rd_addr,
   output logic [K-1:0] rd_data,
   output logic         rd_valid,
   output logic         done,
   output logic         err,
   output logic [S:0]   label_cnt,
   output logic [S:0]   table_cnt
);

   localparam int unsigned Depth = 2 ** S;

   typedef enum logic [1:0] {StIdle, StStart, StCollect, StDone} state_e;

   state_e       state_q, state_d;

   logic [K-1:0] label_mem [Depth];
   logic [K-1:0] table_mem [Depth];
   logic [K-1:0] key0_q, key1_q, mask_q;
   logic [K-1:0] rd_mux;
   logic [K-1:0] rd_data_q;
   logic         rd_valid_q;

   logic         collecting, in_done, done_clear, rd_accept;
   logic         label_we0, label_we1, key_we, table_we, mask_we;

   // Stream words are only meaningful while collecting; everything else is discarded.
   assign collecting = (state_q == StCollect);
   assign in_done    = (state_q == StDone);
   assign done_clear = in_done & clear;
   assign rd_accept  = in_done & rd_en;

   assign label_we0  = collecting & tag[2] & tag[0];
   assign label_we1  = collecting & tag[2] & tag[1];
   assign key_we     = collecting & (tag == 3'b001);
   assign table_we   = collecting & (tag == 3'b010);
   assign mask_we    = collecting & (tag == 3'b011);

   assign gc_start   = (state_q == StStart);
   assign done       = in_done;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;

   // Next-state logic for the collection session.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (arm) state_d = StStart;
         StStart:   state_d = StCollect;
         StCollect: if (tag == 3'b011) state_d = StDone;
         StDone:    if (clear) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State register; reset aborts any collection in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Memory writes; the index1 port is written last so data1 wins on equal indices.
   always_ff @(posedge clk) begin
      if (label_we0) label_mem[index0] <= data0;
      if (label_we1) label_mem[index1] <= data1;
      if (table_we) begin
         table_mem[index0] <= data0;
         table_mem[index1] <= data1;
      end
   end

   // Key and mask registers, zeroed when the host clears a finished session.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key0_q <= '0;
         key1_q <= '0;
         mask_q <= '0;
      end else if (done_clear) begin
         key0_q <= '0;
         key1_q <= '0;
         mask_q <= '0;
      end else begin
         if (key_we) begin
            key0_q <= data0;
            key1_q <= data1;
         end
         if (mask_we) mask_q <= data0;
      end
   end

   // Read source select; register selections ignore all address bits they do not need.
   always_comb begin
      rd_mux = '0;
      unique case (rd_sel)
         2'd0:    rd_mux = label_mem[rd_addr];
         2'd1:    rd_mux = table_mem[rd_addr];
         2'd2:    rd_mux = rd_addr[0] ? key1_q : key0_q;
         default: rd_mux = mask_q;
      endcase
   end

   // Read port register; data holds between accepted reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) rd_data_q <= rd_mux;
      end
   end

`ifdef GC_COLLECT_STATS_EN
   localparam logic [S+1:0] CntMax = (S+2)'(Depth);

   logic [S:0]   label_cnt_q, table_cnt_q;
   logic         err_q, keys_seen_q, err_set;
   logic [1:0]   label_inc;
   logic [S+1:0] label_sum, table_sum;

   // One extra bit of headroom so saturation can be detected before truncation.
   assign label_inc = {1'b0, label_we0} + {1'b0, label_we1};
   assign label_sum = {1'b0, label_cnt_q} + {{S{1'b0}}, label_inc};
   assign table_sum = {1'b0, table_cnt_q} + (S+2)'(2);
   assign err_set   = (key_we & keys_seen_q) | (in_done & (tag != 3'b000));

   // Saturating write counters and sticky protocol error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         label_cnt_q <= '0;
         table_cnt_q <= '0;
         keys_seen_q <= 1'b0;
         err_q       <= 1'b0;
      end else if (done_clear) begin
         label_cnt_q <= '0;
         table_cnt_q <= '0;
         keys_seen_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (label_inc != 2'd0) begin
            label_cnt_q <= (label_sum > CntMax) ? CntMax[S:0] : label_sum[S:0];
         end
         if (table_we) begin
            table_cnt_q <= (table_sum > CntMax) ? CntMax[S:0] : table_sum[S:0];
         end
         if (key_we)  keys_seen_q <= 1'b1;
         if (err_set) err_q       <= 1'b1;
      end
   end

   assign label_cnt = label_cnt_q;
   assign table_cnt = table_cnt_q;
   assign err       = err_q;
`else
   assign label_cnt = '0;
   assign table_cnt = '0;
   assign err       = 1'b0;
`endif

endmodule
